// File: rtl/obstacle_scheduler.sv
// Side-scroller obstacle scheduler: moves slots on each tick and spawns new ones at LFSR-spaced gaps; all outputs registered, one-cycle latency, no backpressure.
// Define OBSTACLE_SPEEDUP_EN to scroll two pixels per tick once 32 obstacles have spawned.
module obstacle_scheduler #(
  parameter int         NUM_SLOTS    = 4,
  parameter int         SCREEN_WIDTH = 160,
  parameter int         GROUND_TOP   = 100,
  parameter int         MIN_GAP      = 16,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   tick,
  input  logic                   hit,
  output logic [1:0]             state,
  output logic [NUM_SLOTS-1:0]   slot_active,
  output logic [8*NUM_SLOTS-1:0] slot_x,
  output logic [7*NUM_SLOTS-1:0] slot_y,
  output logic                   spawn,
  output logic [7:0]             spawn_count
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_HALT = 2'd2} state_t;

  localparam logic [7:0] SPAWN_X  = 8'(SCREEN_WIDTH - 1);
  localparam logic [6:0] Y_HIGH   = 7'(GROUND_TOP - 15);
  localparam logic [6:0] Y_GROUND = 7'(GROUND_TOP);
  localparam logic [7:0] GAP_MIN  = 8'(MIN_GAP);

  state_t                 st;
  logic [7:0]             lfsr;
  logic [7:0]             lfsr_nx;
  logic [7:0]             gap;
  logic [7:0]             gap_reload;
  logic [7:0]             step;
  logic [NUM_SLOTS-1:0]   act_mv;
  logic [NUM_SLOTS-1:0]   act_nx;
  logic [NUM_SLOTS-1:0]   spawn_sel;
  logic [8*NUM_SLOTS-1:0] x_nx;
  logic [7*NUM_SLOTS-1:0] y_nx;
  logic                   slot_free;
  logic                   do_spawn;

  assign state      = st;
  assign lfsr_nx    = {lfsr[6], lfsr[5] ^ lfsr[7], lfsr[4] ^ lfsr[7], lfsr[3] ^ lfsr[7],
                       lfsr[2:0], lfsr[7]};
  assign gap_reload = GAP_MIN + {3'b000, lfsr[5:1]};

`ifdef OBSTACLE_SPEEDUP_EN
  assign step = (spawn_count >= 8'd32) ? 8'd2 : 8'd1;
`else
  assign step = 8'd1;
`endif

  // Movement first, so a slot retiring this tick is already free for the spawn search.
  always_comb begin
    act_mv    = slot_active;
    act_nx    = slot_active;
    x_nx      = slot_x;
    y_nx      = slot_y;
    spawn_sel = '0;
    slot_free = 1'b0;
    do_spawn  = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot_active[i]) begin
        x_nx[8*i +: 8] = slot_x[8*i +: 8] - step;
        if (slot_x[8*i +: 8] < step) act_mv[i] = 1'b0;
      end
    end
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!act_mv[i] && !slot_free) begin
        spawn_sel[i] = 1'b1;
        slot_free    = 1'b1;
      end
    end
    do_spawn = slot_free && (gap == 8'd0);
    act_nx   = act_mv;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (do_spawn && spawn_sel[i]) begin
        act_nx[i]      = 1'b1;
        x_nx[8*i +: 8] = SPAWN_X;
        y_nx[7*i +: 7] = lfsr[0] ? Y_HIGH : Y_GROUND;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= S_IDLE;
      lfsr        <= LFSR_SEED;
      gap         <= GAP_MIN;
      slot_active <= '0;
      slot_x      <= '0;
      slot_y      <= '0;
      spawn       <= 1'b0;
      spawn_count <= 8'd0;
    end else begin
      lfsr  <= lfsr_nx;
      spawn <= 1'b0;
      if (start) begin
        st          <= S_RUN;
        gap         <= GAP_MIN;
        slot_active <= '0;
        slot_x      <= '0;
        slot_y      <= '0;
        spawn_count <= 8'd0;
      end else if (st == S_RUN) begin
        if (hit) begin
          st <= S_HALT;
        end else if (tick) begin
          slot_active <= act_nx;
          slot_x      <= x_nx;
          slot_y      <= y_nx;
          if (do_spawn) begin
            gap   <= gap_reload;
            spawn <= 1'b1;
            if (spawn_count != 8'hFF) spawn_count <= spawn_count + 8'd1;
          end else if (gap != 8'd0) begin
            gap <= gap - 8'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Scoreboard bench: stimulus pushes predicted spawns, a negedge monitor pops and compares them.
// Two instances share stimulus: default parameters and MIN_GAP=0.
`timescale 1ns/1ps
module tb_obstacle_scheduler;
  localparam int NS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic tick = 1'b0;
  logic hit = 1'b0;

  logic [1:0]    state_a, state_b;
  logic [NS-1:0] act_a, act_b;
  logic [8*NS-1:0] x_a, x_b;
  logic [7*NS-1:0] y_a, y_b;
  logic          spawn_a, spawn_b;
  logic [7:0]    cnt_a, cnt_b;

  obstacle_scheduler u_dut (
    .clk(clk), .rst(rst), .start(start), .tick(tick), .hit(hit),
    .state(state_a), .slot_active(act_a), .slot_x(x_a), .slot_y(y_a),
    .spawn(spawn_a), .spawn_count(cnt_a)
  );

  obstacle_scheduler #(.MIN_GAP(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .tick(tick), .hit(hit),
    .state(state_b), .slot_active(act_b), .slot_x(x_b), .slot_y(y_b),
    .spawn(spawn_b), .spawn_count(cnt_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         slot;
    logic [6:0] y;
    logic [7:0] cnt;
  } spawn_t;

  spawn_t exp_qa[$];
  spawn_t exp_qb[$];

  int         vectors = 0;
  int         miscompares = 0;
  int         min_gap [2] = '{16, 0};
  logic [1:0] m_state [2];
  logic [3:0] m_act [2];
  logic [7:0] m_x [2][NS];
  logic [6:0] m_y [2][NS];
  int         m_gap [2];
  int         m_cnt [2];
  logic       m_stall [2];
  logic       m_refill [2];
  logic [7:0] m_lfsr;

  // Reference LFSR, so predicted spawn heights and gap reloads follow the same sequence.
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 8'hA5;
    else     m_lfsr <= {m_lfsr[6], m_lfsr[5] ^ m_lfsr[7], m_lfsr[4] ^ m_lfsr[7],
                        m_lfsr[3] ^ m_lfsr[7], m_lfsr[2:0], m_lfsr[7]};
  end

  task automatic model_clear(input int d);
    m_act[d] = '0;
    m_gap[d] = min_gap[d];
    m_cnt[d] = 0;
    for (int i = 0; i < NS; i++) begin
      m_x[d][i] = 8'd0;
      m_y[d][i] = 7'd0;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      model_clear(d);
      m_state[d]  = 2'd0;
      m_stall[d]  = 1'b0;
      m_refill[d] = 1'b0;
    end
    exp_qa.delete();
    exp_qb.delete();
  endtask

  task automatic model_tick(input int d);
    int         step;
    int         slot;
    logic [3:0] old_act;
    spawn_t     e;
    step = 1;
`ifdef OBSTACLE_SPEEDUP_EN
    if (m_cnt[d] >= 32) step = 2;
`endif
    old_act = m_act[d];
    for (int i = 0; i < NS; i++) begin
      if (m_act[d][i]) begin
        if (int'(m_x[d][i]) < step) m_act[d][i] = 1'b0;
        m_x[d][i] = m_x[d][i] - 8'(step);
      end
    end
    if (m_gap[d] > 0) begin
      m_gap[d] = m_gap[d] - 1;
    end else begin
      slot = -1;
      for (int i = NS - 1; i >= 0; i--) if (!m_act[d][i]) slot = i;
      if (slot < 0) begin
        m_stall[d] = 1'b1;
      end else begin
        m_refill[d]     = old_act[slot];
        m_act[d][slot]  = 1'b1;
        m_x[d][slot]    = 8'd159;
        m_y[d][slot]    = m_lfsr[0] ? 7'd85 : 7'd100;
        m_gap[d]        = min_gap[d] + int'(m_lfsr[5:1]);
        if (m_cnt[d] < 255) m_cnt[d] = m_cnt[d] + 1;
        e.slot = slot;
        e.y    = m_y[d][slot];
        e.cnt  = 8'(m_cnt[d]);
        if (d == 0) exp_qa.push_back(e);
        else        exp_qb.push_back(e);
      end
    end
  endtask

  task automatic model_edge(input logic s, input logic t, input logic h);
    for (int d = 0; d < 2; d++) begin
      m_stall[d]  = 1'b0;
      m_refill[d] = 1'b0;
      if (s) begin
        model_clear(d);
        m_state[d] = 2'd1;
      end else if (m_state[d] == 2'd1 && h) begin
        m_state[d] = 2'd2;
      end else if (m_state[d] == 2'd1 && t) begin
        model_tick(d);
      end
    end
  endtask

  // Called at a falling edge; returns at the next falling edge with outputs settled.
  task automatic cycle(input logic s, input logic t, input logic h);
    start = s;
    tick  = t;
    hit   = h;
    model_edge(s, t, h);
    @(negedge clk);
    start = 1'b0;
    tick  = 1'b0;
    hit   = 1'b0;
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_state(input int d, input string name);
    logic [1:0]      st;
    logic [3:0]      act;
    logic [7:0]      cnt;
    logic [8*NS-1:0] xs, gx, ex;
    logic [7*NS-1:0] ys, gy, ey;
    if (d == 0) begin st = state_a; act = act_a; cnt = cnt_a; xs = x_a; ys = y_a; end
    else        begin st = state_b; act = act_b; cnt = cnt_b; xs = x_b; ys = y_b; end
    gx = '0; ex = '0; gy = '0; ey = '0;
    for (int i = 0; i < NS; i++) begin
      if (m_act[d][i]) begin
        gx[8*i +: 8] = xs[8*i +: 8];
        ex[8*i +: 8] = m_x[d][i];
        gy[7*i +: 7] = ys[7*i +: 7];
        ey[7*i +: 7] = m_y[d][i];
      end
    end
    vectors++;
    if (st != m_state[d] || act != m_act[d] || cnt != 8'(m_cnt[d]) || gx != ex || gy != ey) begin
      miscompares++;
      $display("FAIL %s dut%0d: got st=%0d act=%b x=%h y=%h cnt=%0d, expected st=%0d act=%b x=%h y=%h cnt=%0d",
               name, d, st, act, gx, gy, cnt, m_state[d], m_act[d], ex, ey, m_cnt[d]);
    end
  endtask

  task automatic tick_watch(input int k);
    cycle(1'b0, 1'b1, 1'b0);
    if (m_stall[1]) check_val("full_gap_held", int'(u_dut0.gap), 0);
    if (m_refill[1]) check_state(1, "refill_same_tick");
    if (k % 25 == 0) begin
      check_state(0, "periodic");
      check_state(1, "periodic");
    end
  endtask

  task automatic mon_check(input int d, input logic sp, input logic [3:0] act,
                           input logic [8*NS-1:0] xs, input logic [7*NS-1:0] ys,
                           input logic [7:0] cnt);
    spawn_t e;
    int     qsize;
    if (!sp) return;
    vectors++;
    qsize = (d == 0) ? exp_qa.size() : exp_qb.size();
    if (qsize == 0) begin
      miscompares++;
      $display("FAIL spawn_unexpected dut%0d: got spawn with count %0d, expected none", d, cnt);
      return;
    end
    if (d == 0) e = exp_qa.pop_front();
    else        e = exp_qb.pop_front();
    if (!act[e.slot] || xs[8*e.slot +: 8] != 8'd159 || ys[7*e.slot +: 7] != e.y || cnt != e.cnt) begin
      miscompares++;
      $display("FAIL spawn_check dut%0d slot%0d: got act=%b x=%0d y=%0d cnt=%0d, expected act=1 x=159 y=%0d cnt=%0d",
               d, e.slot, act[e.slot], xs[8*e.slot +: 8], ys[7*e.slot +: 7], cnt, e.y, e.cnt);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        mon_check(0, spawn_a, act_a, x_a, y_a, cnt_a);
        mon_check(1, spawn_b, act_b, x_b, y_b, cnt_b);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_val("rst_state", int'(state_a), 0);
    check_val("rst_active", int'(act_a), 0);
    check_val("rst_x", int'(x_a), 0);
    check_val("rst_y", int'(y_a), 0);
    check_val("rst_spawn", int'(spawn_a), 0);
    check_val("rst_count", int'(cnt_a), 0);
    check_val("rst_lfsr", int'(u_dut.lfsr), 165);
    check_val("rst_gap", int'(u_dut.gap), 16);
    check_val("rst_gap_mingap0", int'(u_dut0.gap), 0);
    rst = 1'b0;

    // Ticks in IDLE do nothing.
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 1'b0);
    check_state(0, "idle_ticks");
    check_state(1, "idle_ticks");

    cycle(1'b1, 1'b0, 1'b0);
    check_val("start_state", int'(state_a), 1);
    check_state(1, "after_start");

    for (int k = 1; k <= 16; k++) tick_watch(k);
    check_val("gap16_count", int'(cnt_a), 0);
    check_val("gap16_active", int'(act_a), 0);

    tick_watch(17);
    check_val("first_spawn_pulse", int'(spawn_a), 1);
    check_val("first_spawn_active0", int'(act_a[0]), 1);
    check_val("first_spawn_x0", int'(x_a[7:0]), 159);
    check_val("first_spawn_count", int'(cnt_a), 1);

    for (int k = 1; k <= 159; k++) tick_watch(k);
    check_val("x0_at_tick159", int'(x_a[7:0]), 0);
    check_val("active0_at_tick159", int'(act_a[0]), 1);
    tick_watch(1);
    check_val("active0_at_tick160", int'(act_a[0]), int'(m_act[0][0]));
    check_state(0, "after_tick160");
    check_state(1, "after_tick160");

    // hit with tick: halt, no movement; then frozen while halted.
    cycle(1'b0, 1'b1, 1'b1);
    check_val("hit_state", int'(state_a), 2);
    check_state(0, "hit_no_move");
    check_state(1, "hit_no_move");
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    check_state(0, "halt_frozen");
    check_state(1, "halt_frozen");
    cycle(1'b1, 1'b0, 1'b0);
    check_val("restart_state", int'(state_a), 1);
    check_val("restart_active", int'(act_b), 0);
    check_state(0, "restart_from_halt");

    for (int k = 1; k <= 20; k++) tick_watch(k);
    cycle(1'b1, 1'b1, 1'b1);
    check_val("start_priority_state", int'(state_b), 1);
    check_val("start_priority_active", int'(act_b), 0);
    check_val("start_priority_count", int'(cnt_b), 0);
    for (int k = 1; k <= 25; k++) tick_watch(k);
    check_state(0, "second_run");

    // Asynchronous reset between edges.
    #2;
    rst = 1'b1;
    #1;
    check_val("arst_state", int'(state_a), 0);
    check_val("arst_active", int'(act_a), 0);
    check_val("arst_x", int'(x_a), 0);
    check_val("arst_y", int'(y_a), 0);
    check_val("arst_count", int'(cnt_a), 0);
    check_val("arst_lfsr", int'(u_dut.lfsr), 165);
    check_val("arst_active_mingap0", int'(act_b), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 1'b0);
    check_val("post_rst_spawn", int'(spawn_b), 0);
    check_state(0, "post_rst_idle");
    check_state(1, "post_rst_idle");

`ifdef OBSTACLE_SPEEDUP_EN
    cycle(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 3000 && m_cnt[0] < 34; k++) tick_watch(k);
    for (int k = 1; k <= 60; k++) begin
      tick_watch(k);
      check_state(0, "speedup_step2");
    end
`endif

    @(negedge clk);
    check_val("pending_spawns_a", exp_qa.size(), 0);
    check_val("pending_spawns_b", exp_qb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/obstacle_scheduler.md
OBSTACLE_SCHEDULER -- requirements
Module: obstacle_scheduler

Interface
REQ-001 Parameter NUM_SLOTS, default 4, number of obstacle slots.
REQ-002 Parameter SCREEN_WIDTH, default 160, spawn x origin; the spawn x value SHALL be SCREEN_WIDTH-1.
REQ-003 Parameter GROUND_TOP, default 100, ground-level obstacle y.
REQ-004 Parameter MIN_GAP, default 16, minimum ticks between spawns.
REQ-005 Parameter LFSR_SEED, default 8'hA5, non-zero LFSR reset value.
REQ-006 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 start  input  1  one-cycle pulse that begins or restarts a run.
REQ-009 tick  input  1  one-cycle frame-step pulse.
REQ-010 hit  input  1  collision flag from the external detector.
REQ-011 state  output  2  0=IDLE, 1=RUN, 2=HALT.
REQ-012 slot_active  output  NUM_SLOTS  per-slot occupied flag.
REQ-013 slot_x  output  8*NUM_SLOTS  packed x positions; slot i occupies bits [8i+7:8i].
REQ-014 slot_y  output  7*NUM_SLOTS  packed y positions; slot i occupies bits [7i+6:7i].
REQ-015 spawn  output  1  one-cycle pulse asserted in the cycle after a spawn.
REQ-016 spawn_count  output  8  number of spawns since the last start; saturates at 255.

Function
REQ-017 The LFSR SHALL be 8 bits and advance every clk cycle in all states, with next = {r6, r5^r7, r4^r7, r3^r7, r2, r1, r0, r7} (MSB first).
REQ-018 IDLE: start SHALL clear all slots, load gap = MIN_GAP, zero spawn_count, and enter RUN.
REQ-019 In RUN, each tick SHALL decrement x by step (REQ-033) in every active slot, and SHALL clear slot_active for any slot whose x < step before the update; x is then don't-care.
REQ-020 In RUN, each tick SHALL decrement gap when gap > 0.
REQ-021 When a tick arrives with gap == 0 and a free slot exists, the lowest-index free slot SHALL be loaded with x = SCREEN_WIDTH-1 and y = GROUND_TOP-15 if lfsr[0] is 1, else y = GROUND_TOP.
REQ-022 On a spawn, gap SHALL reload to MIN_GAP + lfsr[5:1].
REQ-023 On a spawn, spawn SHALL assert for one cycle and spawn_count SHALL increment.
REQ-024 If gap == 0 and no slot is free, no spawn SHALL occur; gap SHALL stay 0 and the spawn SHALL retry on the next tick.
REQ-025 A slot freed on a tick SHALL be usable for a spawn in that same tick; a newly spawned slot SHALL NOT move on its spawn tick.
REQ-026 In RUN, hit SHALL move the state to HALT on the next edge, and a tick in the same cycle as hit SHALL be ignored (no movement, no spawn).
REQ-027 In HALT, all slot outputs SHALL hold and tick SHALL be ignored; start SHALL re-initialise as in REQ-018 and enter RUN.
REQ-028 In RUN, start SHALL restart the run as in REQ-018; start SHALL take priority over tick and hit in the same cycle.
REQ-029 All outputs SHALL be registered, with zero combinational paths from inputs to outputs.

Reset
REQ-030 rst SHALL immediately force state=IDLE, slot_active=0, slot_x=0, slot_y=0, spawn=0, spawn_count=0, gap=MIN_GAP, and lfsr=LFSR_SEED.
REQ-031 rst asserted mid-run SHALL discard all slots; no spawn pulse SHALL be emitted after release until a new start.

Configuration
REQ-032 Macro OBSTACLE_SPEEDUP_EN SHALL select the movement step.
REQ-033 With OBSTACLE_SPEEDUP_EN defined, step SHALL be 2 once spawn_count >= 32 and 1 otherwise; without it, step SHALL always be 1 and no comparison logic SHALL be present.

Verification
REQ-034 Reset, start, 16 ticks -> first spawn on the 17th tick: slot 0 active, x=159, spawn pulse, spawn_count=1.
REQ-035 Spawned slot followed by 160 further ticks -> x reaches 0 on tick 159 and slot_active[0] clears on tick 160.
REQ-036 MIN_GAP=0 with all 4 slots full -> no spawn and gap=0 held; the next freed slot is respawned on the same tick it frees.
REQ-037 hit and tick asserted together in RUN -> state=HALT with no x change; further ticks -> outputs frozen; start -> RUN with slots cleared.
REQ-038 rst asserted between edges mid-run -> outputs reach reset values before the next edge, and lfsr=8'hA5.
REQ-039 With OBSTACLE_SPEEDUP_EN defined, after 32 spawns -> active x decreases by 2 per tick, and a slot with x=1 deactivates.
